poly_horner_mac: RTL
====================

// Module: poly_horner_mac
// PURPOSE
//  Parametrised successor to the fixed quadratic datapath. Evaluates an unsigned
//  polynomial c[d]*x^d + ... + c[0], degree d selectable per request up to DEGREE.
//  Uses Horner's rule on one shared multiply-accumulate stage, one step per cycle.
//  Coefficients live in a local register file. Requests and results use
//  valid/ready handshakes, so the block sits between a stimulus source and a consumer.
// PARAMETERS
//  DATA_W  8   width of x and of each coefficient
//  ACC_W   16  accumulator/result width (must be >= DATA_W)
//  DEGREE  4   maximum polynomial degree; the register file holds DEGREE+1 coefficients
// PORTS
//  clk        in   1         clock, rising edge
//  reset      in   1         asynchronous, active-high reset
//  coef_we    in   1         coefficient write strobe
//  coef_addr  in   DEG_W     coefficient index 0..DEGREE, DEG_W=$clog2(DEGREE+1)
//  coef_data  in   DATA_W    coefficient value
//  in_valid   in   1         evaluation request valid
//  in_ready   out  1         block can accept a request (high only in IDLE)
//  in_x       in   DATA_W    evaluation point
//  in_deg     in   DEG_W     requested degree d
//  out_valid  out  1         result valid
//  out_ready  in   1         consumer accepts the result
//  result     out  ACC_W     polynomial value
//  overflow   out  1         sticky per evaluation: some step exceeded ACC_W
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready=1; out_valid=0; result=0; overflow=0.
//    All coefficients and the accumulator are cleared to 0. Reset is honoured mid-run:
//    the run is aborted and no result is produced.
//  - FSM states: IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: in_ready=1. Accept on in_valid&in_ready:
//      latch x and d, where d=min(in_deg,DEGREE); acc<=c[d]; idx<=d; overflow<=0.
//      Next state is RUN when d>0, DONE when d==0.
//  - RUN: each cycle acc<=acc*x+c[idx-1]; idx<=idx-1. Go to DONE when idx reaches 0.
//  - Latency: out_valid rises d+1 cycles after the accepting edge (d=0 gives 1 cycle).
//  - DONE: out_valid=1; result and overflow are held stable until out_valid&out_ready.
//    On that handshake go to IDLE, deassert out_valid on the next edge and keep the
//    result value. A new request is accepted at the earliest on the cycle after.
//  - Arithmetic: product is ACC_W x DATA_W; c is zero-extended; the full sum is formed
//    at ACC_W+DATA_W+1 bits. A step overflows when any bit above ACC_W-1 is set;
//    overflow ORs across the steps of one evaluation.
//  - Coefficient writes: applied on the clock edge when state==IDLE. They are silently
//    ignored in RUN and DONE so the polynomial is stable during evaluation.
//    A write and an accept in the same IDLE cycle: the accept reads the pre-write value.
//  - coef_addr > DEGREE: write ignored.
// CONFIGURATION
//  POLY_SAT_EN defined: each step whose sum overflows clamps acc to {ACC_W{1'b1}}.
//    This yields min(true value, 2^ACC_W-1) exactly, because clamping is
//    monotone-safe for unsigned Horner.
//  POLY_SAT_EN undefined: each step wraps modulo 2^ACC_W.
//  overflow reports identically in both builds.
// STRUCTURE
//  - Package poly_pkg: state_t enum {IDLE,RUN,DONE}; function deg_w(DEGREE) for $clog2 sizing.
//  - Sub-module poly_mac_step (combinational): inputs acc, x, c; outputs next_acc and
//    step_ovf. The POLY_SAT_EN choice is made inside it.
//  - Top level: FSM, register file, handshakes.
// TESTING (defaults DATA_W=8, ACC_W=16, DEGREE=4)
//  1. Load c2=3,c1=5,c0=7; request x=4, d=2 -> result=75, overflow=0,
//     out_valid 3 cycles after accept.
//  2. c0=9, d=0, x=200 -> result=9 one cycle after accept; c1..c4 have no effect.
//  3. c4=1, others 0, x=16, d=4 -> overflow=1; result=0x0000 without POLY_SAT_EN,
//     0xFFFF with it.
//  4. Hold out_ready=0 for 5 cycles in DONE and pulse coef_we c0=99 ->
//     result/overflow stable, in_ready=0, c0 unchanged on the next run.
//  5. in_deg=7 with DEGREE=4 -> evaluated as degree 4; c=1,1,1,1,1, x=2 -> result=31.
//  6. Assert reset two cycles into a d=4 run -> out_valid never rises, in_ready=1 after
//     release, all coefficients read 0 (next d=2, x=3 -> result=0).

Source files
------------

// File: rtl/poly_pkg.sv
// Shared types and sizing helpers for the Horner polynomial evaluator.
package poly_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   // Width of an index that can address coefficients 0..degree.
   function automatic int deg_w(input int degree);
      return (degree < 1) ? 1 : $clog2(degree + 1);
   endfunction

endpackage

// File: rtl/poly_mac_step.sv
// One Horner step: next_acc = acc * x + c, with overflow detection.
// Build option POLY_SAT_EN: an overflowing step clamps to all-ones instead of wrapping.
module poly_mac_step #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 16
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic [DATA_W-1:0] x,
   input  logic [DATA_W-1:0] c,
   output logic [ACC_W-1:0]  next_acc,
   output logic              step_ovf
);

   localparam int SUM_W = ACC_W + DATA_W + 1;

   logic [SUM_W-1:0] sum;

   // Full-width multiply-add; any bit above the accumulator width is an overflow.
   always_comb begin
      sum      = SUM_W'(acc) * SUM_W'(x) + SUM_W'(c);
      step_ovf = |sum[SUM_W-1:ACC_W];
`ifdef POLY_SAT_EN
      next_acc = step_ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
      next_acc = sum[ACC_W-1:0];
`endif
   end

endmodule

// File: rtl/poly_horner_mac.sv
// Unsigned polynomial evaluator using Horner's rule, one MAC step per cycle.
// Coefficient register file is writable only while idle.
// Build option POLY_SAT_EN selects saturating accumulation (see poly_mac_step).
//
// state | meaning
// IDLE  | ready for a request; coefficient writes applied here
// RUN   | one Horner step per cycle, idx counts down to 0
// DONE  | result valid, held until the consumer accepts it
module poly_horner_mac
   import poly_pkg::*;
#(
   parameter  int DATA_W = 8,
   parameter  int ACC_W  = 16,
   parameter  int DEGREE = 4,
   localparam int DEG_W  = deg_w(DEGREE)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              coef_we,
   input  logic [DEG_W-1:0]  coef_addr,
   input  logic [DATA_W-1:0] coef_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_x,
   input  logic [DEG_W-1:0]  in_deg,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  result,
   output logic              overflow
);

   localparam logic [DEG_W-1:0] DEG_MAX = DEG_W'(DEGREE);

   state_t            state_q, state_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [DATA_W-1:0] x_q, x_d;
   logic [DEG_W-1:0]  idx_q, idx_d;
   logic              ovf_q, ovf_d;
   logic [DATA_W-1:0] coef_q [DEGREE+1];
   logic [DATA_W-1:0] coef_d [DEGREE+1];

   logic [DEG_W-1:0]  req_deg;
   logic [DEG_W-1:0]  idx_m1;
   logic [ACC_W-1:0]  step_acc;
   logic              step_ovf;

   assign req_deg   = (in_deg > DEG_MAX) ? DEG_MAX : in_deg;
   assign idx_m1    = idx_q - DEG_W'(1);
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = acc_q;
   assign overflow  = ovf_q;

   poly_mac_step #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_step (
      .acc      (acc_q),
      .x        (x_q),
      .c        (coef_q[idx_m1]),
      .next_acc (step_acc),
      .step_ovf (step_ovf)
   );

   // Next-state logic: request accept, Horner iteration, result handoff, coefficient writes.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      x_d     = x_q;
      idx_d   = idx_q;
      ovf_d   = ovf_q;
      coef_d  = coef_q;
      case (state_q)
         IDLE: begin
            // The accept below reads coef_q, so a same-cycle write is not seen by it.
            if (coef_we && (coef_addr <= DEG_MAX)) begin
               coef_d[coef_addr] = coef_data;
            end
            if (in_valid) begin
               x_d     = in_x;
               idx_d   = req_deg;
               acc_d   = coef_q[req_deg];
               ovf_d   = 1'b0;
               state_d = (req_deg == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            acc_d = step_acc;
            ovf_d = ovf_q | step_ovf;
            idx_d = idx_m1;
            if (idx_m1 == '0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, datapath and coefficient registers; reset aborts any run in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         x_q     <= '0;
         idx_q   <= '0;
         ovf_q   <= 1'b0;
         for (int i = 0; i <= DEGREE; i++) begin
            coef_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         x_q     <= x_d;
         idx_q   <= idx_d;
         ovf_q   <= ovf_d;
         coef_q  <= coef_d;
      end
   end

endmodule
